// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: two-stage immediate-extension / target-generation unit.
// S1 captures the instruction fields, S2 holds the computed result. Both
// stages carry a valid bit and a plain valid/ready handshake, so up to two
// entries can be held under back-pressure. Flush drops everything in flight.
module ext_unit_pipe #(
   parameter int W      = 32,
   parameter int IMM_W  = 16,
   parameter int JMP_W  = 26,
   parameter int SA_LSB = 6,
   parameter int SA_W   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_mode,
   input  logic [IMM_W-1:0] in_imm,
   input  logic [JMP_W-1:0] in_jidx,
   input  logic [W-1:0]     in_pc4,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             out_err
);

   typedef enum logic [2:0] {
      MODE_SIGN   = 3'd0,
      MODE_UNSI   = 3'd1,
      MODE_LUI    = 3'd2,
      MODE_SA     = 3'd3,
      MODE_JUMP   = 3'd4,
      MODE_BRANCH = 3'd5
   } mode_t;

   // Low bits of pc4 that the jump index replaces (index plus the two zero LSBs).
   localparam logic [W-1:0] JMP_MASK = (W'(1) << (JMP_W + 2)) - W'(1);

   logic             s1_valid;
   logic [2:0]       s1_mode;
   logic [IMM_W-1:0] s1_imm;
   logic [JMP_W-1:0] s1_jidx;
   logic [W-1:0]     s1_pc4;
   logic             s2_valid;
   logic             s2_adv;
   logic             accept;
   logic [W-1:0]     sext;
   logic [W-1:0]     result;
   logic             result_err;

   assign s2_adv    = !s2_valid || out_ready;
   // Gating with rst_n keeps the producer from handing over a request that
   // the reset edge would throw away anyway.
   assign in_ready  = (!s1_valid || s2_adv) && !flush && rst_n;
   assign accept    = in_valid && in_ready;
   assign out_valid = s2_valid;

   // Result selection from the S1 fields; reserved modes fall back to SIGN and flag an error.
   always_comb begin
      sext       = W'($signed(s1_imm));
      result     = sext;
      result_err = 1'b0;
      case (s1_mode)
         MODE_SIGN:   result = sext;
         MODE_UNSI:   result = W'(s1_imm);
         MODE_LUI:    result = W'(s1_imm) << (W - IMM_W);
         MODE_SA:     result = W'(s1_imm[SA_LSB+SA_W-1:SA_LSB]);
         MODE_JUMP:   result = (s1_pc4 & ~JMP_MASK) | (W'(s1_jidx) << 2);
         MODE_BRANCH: result = s1_pc4 + (sext << 2);
         default: begin
            result     = sext;
            result_err = 1'b1;
         end
      endcase
   end

   // Pipeline registers: reset clears everything, flush clears only the valid bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_mode  <= '0;
         s1_imm   <= '0;
         s1_jidx  <= '0;
         s1_pc4   <= '0;
         s2_valid <= 1'b0;
         out_data <= '0;
         out_err  <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               out_data <= result;
               out_err  <= result_err;
            end
         end
         if (accept) begin
            s1_valid <= 1'b1;
            s1_mode  <= in_mode;
            s1_imm   <= in_imm;
            s1_jidx  <= in_jidx;
            s1_pc4   <= in_pc4;
         end else if (s2_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Directed bench for ext_unit_pipe: mode sweep, wrap cases, back-pressure,
// flush, reserved mode and mid-flight reset. Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_ext_unit_pipe;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_mode;
   logic [15:0] in_imm;
   logic [25:0] in_jidx;
   logic [31:0] in_pc4;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_err;

   int checks = 0;
   int errors = 0;

   ext_unit_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_imm    (in_imm),
      .in_jidx   (in_jidx),
      .in_pc4    (in_pc4),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] m, input logic [15:0] imm,
                        input logic [25:0] jidx, input logic [31:0] pc4);
      in_valid = 1'b1;
      in_mode  = m;
      in_imm   = imm;
      in_jidx  = jidx;
      in_pc4   = pc4;
   endtask

   // One request through an empty pipe with out_ready held high.
   task automatic do_one(input string tag, input logic [2:0] m, input logic [15:0] imm,
                         input logic [25:0] jidx, input logic [31:0] pc4,
                         input logic [31:0] exp, input logic exp_err);
      out_ready = 1'b1;
      drive(m, imm, jidx, pc4);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk({tag, "_lat_s1"}, 32'(out_valid), 32'd0);
      tick();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, out_data, exp);
      chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
      tick();
      chk({tag, "_taken"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_mode   = '0;
      in_imm    = '0;
      in_jidx   = '0;
      in_pc4    = '0;
      out_ready = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      tick();

      // Mode sweep
      do_one("sign",   3'd0, 16'h8000, 26'h0, 32'h0040_0010, 32'hFFFF_8000, 1'b0);
      do_one("unsi",   3'd1, 16'h8000, 26'h0, 32'h0040_0010, 32'h0000_8000, 1'b0);
      do_one("lui",    3'd2, 16'h1234, 26'h0, 32'h0040_0010, 32'h1234_0000, 1'b0);
      do_one("sa",     3'd3, 16'h07C0, 26'h0, 32'h0040_0010, 32'h0000_001F, 1'b0);
      do_one("branch", 3'd5, 16'hFFFF, 26'h0, 32'h0040_0010, 32'h0040_000C, 1'b0);
      do_one("jump",   3'd4, 16'h0000, 26'h0100000, 32'h8000_0004, 32'h8040_0000, 1'b0);
      do_one("brwrap", 3'd5, 16'h0001, 26'h0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
      do_one("resv7",  3'd7, 16'h8001, 26'h0, 32'h0, 32'hFFFF_8001, 1'b1);
      do_one("signok", 3'd0, 16'h0001, 26'h0, 32'h0, 32'h0000_0001, 1'b0);

      // Back-pressure: two held, third refused, in-order drain
      out_ready = 1'b0;
      drive(3'd1, 16'h0011, 26'h0, 32'h0);
      chk("bp_rdy1", 32'(in_ready), 32'd1);
      tick();
      drive(3'd1, 16'h0022, 26'h0, 32'h0);
      chk("bp_rdy2", 32'(in_ready), 32'd1);
      tick();
      drive(3'd1, 16'h0033, 26'h0, 32'h0);
      chk("bp_rdy3", 32'(in_ready), 32'd0);
      chk("bp_hold_v", 32'(out_valid), 32'd1);
      chk("bp_hold_d", out_data, 32'h11);
      tick();
      chk("bp_stable_d", out_data, 32'h11);
      chk("bp_still_full", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      #0;
      chk("bp_release_rdy", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_drain2", out_data, 32'h22);
      tick();
      chk("bp_drain3_v", 32'(out_valid), 32'd1);
      chk("bp_drain3", out_data, 32'h33);
      tick();
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Flush with both stages full and an input offered
      out_ready = 1'b0;
      drive(3'd1, 16'h0044, 26'h0, 32'h0);
      tick();
      drive(3'd1, 16'h0055, 26'h0, 32'h0);
      tick();
      drive(3'd1, 16'h0066, 26'h0, 32'h0);
      flush = 1'b1;
      #0;
      chk("fl_in_ready", 32'(in_ready), 32'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      tick();
      chk("fl_lost", 32'(out_valid), 32'd0);
      do_one("fl_next", 3'd2, 16'hABCD, 26'h0, 32'h0, 32'hABCD_0000, 1'b0);

      // Reset with two entries in flight
      out_ready = 1'b0;
      drive(3'd6, 16'h9000, 26'h0, 32'h0);
      tick();
      drive(3'd1, 16'h0077, 26'h0, 32'h0);
      tick();
      in_valid = 1'b0;
      chk("pre_rst_err", 32'(out_err), 32'd1);
      chk("pre_rst_data", out_data, 32'hFFFF_9000);
      rst_n = 1'b0;
      #0;
      chk("mid_rst_rdy", 32'(in_ready), 32'd0);
      tick();
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", out_data, 32'd0);
      chk("mid_rst_err", 32'(out_err), 32'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("post_rst_empty", 32'(out_valid), 32'd0);
      do_one("post_rst", 3'd5, 16'h0004, 26'h0, 32'h0000_1000, 32'h0000_1010, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
